// File: rtl/issue_queue_if.sv
// Handshake bundle between decode, the scoreboard and the functional-unit dispatch.
// The slave side is the issue buffer; the master side is whoever drives decode/scoreboard inputs.
interface issue_queue_if #(
    parameter int PAYLOAD_WIDTH     = 64,
    parameter int FUNC_UNIT_OP_SIZE = 3,
    parameter int STALL_CNT_WIDTH   = 16
);
    logic                             in_valid;
    logic [PAYLOAD_WIDTH-1:0]         in_payload;
    logic [FUNC_UNIT_OP_SIZE-1:0]     in_func_unit;
    logic                             in_ready;
    logic                             head_valid;
    logic [PAYLOAD_WIDTH-1:0]         head_payload;
    logic [FUNC_UNIT_OP_SIZE-1:0]     head_func_unit;
    logic                             resource_stall;
    logic                             issue;
    logic                             flush;
    logic                             disp_valid;
    logic [PAYLOAD_WIDTH-1:0]         disp_payload;
    logic [(1<<FUNC_UNIT_OP_SIZE)-1:0] disp_unit_sel;
    logic [STALL_CNT_WIDTH-1:0]       stall_cycles;

    modport master (
        output in_valid, in_payload, in_func_unit, resource_stall, flush,
        input  in_ready, head_valid, head_payload, head_func_unit, issue,
               disp_valid, disp_payload, disp_unit_sel, stall_cycles
    );

    modport slave (
        input  in_valid, in_payload, in_func_unit, resource_stall, flush,
        output in_ready, head_valid, head_payload, head_func_unit, issue,
               disp_valid, disp_payload, disp_unit_sel, stall_cycles
    );
endinterface

// File: rtl/issue_queue.sv
// Two-entry in-order issue buffer: holds decoded instructions, issues the head when the
// scoreboard allows, and launches it through a one-cycle registered dispatch slot.
module issue_queue #(
    parameter int PAYLOAD_WIDTH     = 64,
    parameter int FUNC_UNIT_OP_SIZE = 3,
    parameter int STALL_CNT_WIDTH   = 16
) (
    input  logic          clk,
    input  logic          reset,
    issue_queue_if.slave  bus
);
    localparam int NUM_UNITS = 1 << FUNC_UNIT_OP_SIZE;

    logic [PAYLOAD_WIDTH-1:0]     entry_payload_reg [2];
    logic [FUNC_UNIT_OP_SIZE-1:0] entry_unit_reg    [2];
    logic                         rd_ptr_reg;
    logic                         wr_ptr_reg;
    logic [1:0]                   count_reg;
    logic [1:0]                   count_next;

    logic                         disp_valid_reg;
    logic [PAYLOAD_WIDTH-1:0]     disp_payload_reg;
    logic [FUNC_UNIT_OP_SIZE-1:0] disp_unit_reg;
    logic [STALL_CNT_WIDTH-1:0]   stall_cycles_reg;

    logic head_valid;
    logic in_ready;
    logic issue;
    logic enq;

    // in_ready looks only at the registered count, so a full buffer never accepts
    // in the same cycle its head leaves.
    assign head_valid = (count_reg != 2'd0);
    assign in_ready   = (count_reg != 2'd2) && !bus.flush;
    assign issue      = head_valid && !bus.resource_stall && !bus.flush;
    assign enq        = bus.in_valid && in_ready;

    always_comb begin
        count_next = count_reg;
        if (enq && !issue) begin
            count_next = count_reg + 2'd1;
        end else if (!enq && issue) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entry_payload_reg[wr_ptr_reg] <= bus.in_payload;
            entry_unit_reg[wr_ptr_reg]    <= bus.in_func_unit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (enq) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (issue) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // issue is already suppressed by flush, so the slot empties on a flush too.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_valid_reg   <= 1'b0;
            disp_payload_reg <= '0;
            disp_unit_reg    <= '0;
        end else begin
            disp_valid_reg <= issue;
            if (issue) begin
                disp_payload_reg <= entry_payload_reg[rd_ptr_reg];
                disp_unit_reg    <= entry_unit_reg[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (head_valid && bus.resource_stall && !bus.flush && !(&stall_cycles_reg)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit_sel
        assign bus.disp_unit_sel[gi] = disp_valid_reg &&
                                       (disp_unit_reg == FUNC_UNIT_OP_SIZE'(gi));
    end

    assign bus.in_ready       = in_ready;
    assign bus.head_valid     = head_valid;
    assign bus.head_payload   = entry_payload_reg[rd_ptr_reg];
    assign bus.head_func_unit = entry_unit_reg[rd_ptr_reg];
    assign bus.issue          = issue;
    assign bus.disp_valid     = disp_valid_reg;
    assign bus.disp_payload   = disp_payload_reg;
    assign bus.stall_cycles   = stall_cycles_reg;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed steps then random traffic, every cycle checked against
// a queue-based model; a second instance with a 3-bit stall counter shares the stimulus.
module tb_issue_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    issue_queue_if #(.PAYLOAD_WIDTH(64), .FUNC_UNIT_OP_SIZE(3), .STALL_CNT_WIDTH(16)) bus ();
    issue_queue_if #(.PAYLOAD_WIDTH(64), .FUNC_UNIT_OP_SIZE(3), .STALL_CNT_WIDTH(3))  bus_s ();

    issue_queue #(.PAYLOAD_WIDTH(64), .FUNC_UNIT_OP_SIZE(3), .STALL_CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    issue_queue #(.PAYLOAD_WIDTH(64), .FUNC_UNIT_OP_SIZE(3), .STALL_CNT_WIDTH(3)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    assign bus_s.in_valid       = bus.in_valid;
    assign bus_s.in_payload     = bus.in_payload;
    assign bus_s.in_func_unit   = bus.in_func_unit;
    assign bus_s.resource_stall = bus.resource_stall;
    assign bus_s.flush          = bus.flush;

    typedef struct {
        logic [63:0] p;
        logic [2:0]  u;
    } ent_t;

    ent_t        m_q[$];
    logic        m_dv;
    logic [63:0] m_dp;
    logic [2:0]  m_du;
    int          m_stall;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare every visible output with the model, then clock
    // the model with the same inputs.
    task automatic step(input logic v, input logic [63:0] p, input logic [2:0] u,
                        input logic st, input logic fl, input logic rs);
        logic e_ready, e_hv, e_issue;
        logic [7:0] e_sel;
        ent_t e;
        bus.in_valid       = v;
        bus.in_payload     = p;
        bus.in_func_unit   = u;
        bus.resource_stall = st;
        bus.flush          = fl;
        reset              = rs;
        #1;
        e_ready = (m_q.size() < 2) && !fl;
        e_hv    = (m_q.size() > 0);
        e_issue = e_hv && !st && !fl;
        e_sel   = m_dv ? (8'd1 << m_du) : 8'd0;
        chk("in_ready",   64'(bus.in_ready),   64'(e_ready));
        chk("head_valid", 64'(bus.head_valid), 64'(e_hv));
        chk("issue",      64'(bus.issue),      64'(e_issue));
        if (e_hv) begin
            chk("head_payload",   bus.head_payload,        m_q[0].p);
            chk("head_func_unit", 64'(bus.head_func_unit), 64'(m_q[0].u));
        end
        chk("disp_valid",    64'(bus.disp_valid),    64'(m_dv));
        if (m_dv) chk("disp_payload", bus.disp_payload, m_dp);
        chk("disp_unit_sel", 64'(bus.disp_unit_sel), 64'(e_sel));
        chk("stall_cycles",  64'(bus.stall_cycles),  64'((m_stall > 65535) ? 65535 : m_stall));
        chk("stall_sat3",    64'(bus_s.stall_cycles), 64'((m_stall > 7) ? 7 : m_stall));
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_dv = 1'b0; m_dp = '0; m_du = '0; m_stall = 0;
        end else if (fl) begin
            m_q.delete();
            m_dv = 1'b0;
        end else begin
            if (e_hv && st) m_stall++;
            m_dv = e_issue;
            if (e_issue) begin
                e = m_q.pop_front();
                m_dp = e.p;
                m_du = e.u;
            end
            if (v && e_ready) begin
                e.p = p;
                e.u = u;
                m_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 64'h0, 3'd0, st, 1'b0, 1'b0);
    endtask

    initial begin
        m_dv = 1'b0; m_dp = '0; m_du = '0; m_stall = 0;
        bus.in_valid = 1'b0; bus.in_payload = '0; bus.in_func_unit = '0;
        bus.resource_stall = 1'b0; bus.flush = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        // Reset state is checked by the first ordinary step.
        idle(1'b0);

        // Single instruction with no stall.
        step(1'b1, 64'h1234, 3'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t1_disp_valid", 64'(bus.disp_valid), 64'd1);
        chk("t1_disp_payload", bus.disp_payload, 64'h1234);
        chk("t1_unit_sel", 64'(bus.disp_unit_sel), 64'h08);
        idle(1'b0);

        // Fill under stall, C held back, then drain in order.
        step(1'b1, 64'hA, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hB, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hC, 3'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hC, 3'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hC, 3'd5, 1'b0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0); idle(1'b0);

        // Stall counter and 3-bit saturation.
        step(1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h55, 3'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("stall5", 64'(bus.stall_cycles), 64'd5);
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("stall15", 64'(bus.stall_cycles), 64'd15);
        chk("stall_sat7", 64'(bus_s.stall_cycles), 64'd7);

        // Flush with a full buffer, then with a live dispatch slot.
        step(1'b1, 64'h66, 3'd6, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h77, 3'd7, 1'b1, 1'b1, 1'b0);
        chk("flush_hv", 64'(bus.head_valid), 64'd0);
        step(1'b1, 64'h88, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h99, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hAA, 3'd2, 1'b0, 1'b1, 1'b0);
        chk("flush_dv", 64'(bus.disp_valid), 64'd0);
        idle(1'b0);

        // Pointer wrap: six back-to-back instructions.
        for (int i = 0; i < 6; i++) step(1'b1, 64'h100 + 64'(i), 3'(i + 2), 1'b0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);

        // Reset in the middle of traffic.
        step(1'b1, 64'hD0, 3'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hD1, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hD2, 3'd5, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_hv", 64'(bus.head_valid), 64'd0);
        chk("rst_dv", 64'(bus.disp_valid), 64'd0);
        chk("rst_stall", 64'(bus.stall_cycles), 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(9, 0) < 7,
                 {$urandom, $urandom},
                 3'($urandom_range(7, 0)),
                 $urandom_range(9, 0) < 3,
                 $urandom_range(39, 0) == 0,
                 $urandom_range(99, 0) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
